// File: rtl/nanosoc_axi_stream_io_fifo_buffer.sv
// nanosoc_axi_stream_io_fifo_buffer
// Multi-entry AXI-stream FIFO with fill level and almost-full status.
//
// Ports:
//   aclk       - clock, all state updates on the rising edge
//   areset     - asynchronous, active-high reset
//   rxd_valid  - upstream beat valid
//   rxd_ready  - FIFO can accept a beat (count != DEPTH)
//   rxd_data   - upstream payload, DATA_W bits
//   txd_valid  - FIFO holds at least one beat (count != 0)
//   txd_ready  - downstream accepts the head beat
//   txd_data   - head-of-FIFO payload, DATA_W bits
//   level      - current occupancy, 0..DEPTH
//   afull      - level >= AFULL_LVL
//
// Optional feature (macro NANOSOC_AXI_STREAM_FIFO_LAST_EN):
//   rxd_last   - upstream end-of-packet marker, stored per entry
//   txd_last   - end-of-packet marker of the head entry
//
// Every output is decoded from registered state only, so there is no
// combinational path from the input side to the output side, and none
// from txd_ready to rxd_ready.

module nanosoc_axi_stream_io_fifo_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     rxd_valid,
    output logic                     rxd_ready,
    input  logic [DATA_W-1:0]        rxd_data,
`ifdef NANOSOC_AXI_STREAM_FIFO_LAST_EN
    input  logic                     rxd_last,
    output logic                     txd_last,
`endif
    output logic                     txd_valid,
    input  logic                     txd_ready,
    output logic [DATA_W-1:0]        txd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     afull
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

`ifdef NANOSOC_AXI_STREAM_FIFO_LAST_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LVL);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Status decode from the registered count only.
    assign rxd_ready = (count != CNT_FULL);
    assign txd_valid = (count != '0);
    assign level     = count;
    assign afull     = (count >= CNT_AFULL);

    assign push = rxd_valid & rxd_ready;
    assign pop  = txd_valid & txd_ready;

`ifdef NANOSOC_AXI_STREAM_FIFO_LAST_EN
    assign wr_entry = {rxd_last, rxd_data};
    assign txd_last = rd_entry[DATA_W];
`else
    assign wr_entry = rxd_data;
`endif

    // Head entry read straight out of storage; it only changes on a pop,
    // which gives the AXI-stream hold behaviour for free.
    assign rd_entry = mem[rd_ptr];
    assign txd_data = rd_entry[DATA_W-1:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); count alone tells
    // full from empty.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_nanosoc_axi_stream_io_fifo_buffer.sv
// tb_nanosoc_axi_stream_io_fifo_buffer
// Vector table plus queue-model checks for the stream FIFO.

module tb_nanosoc_axi_stream_io_fifo_buffer;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 3;

    logic       aclk;
    logic       areset;
    logic       rxd_valid;
    logic       rxd_ready;
    logic [7:0] rxd_data;
    logic       txd_valid;
    logic       txd_ready;
    logic [7:0] txd_data;
    logic [2:0] level;
    logic       afull;

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int n_pop  = 0;

    logic [7:0] mq [$];

    nanosoc_axi_stream_io_fifo_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .rxd_valid(rxd_valid),
        .rxd_ready(rxd_ready),
        .rxd_data (rxd_data),
        .txd_valid(txd_valid),
        .txd_ready(txd_ready),
        .txd_data (txd_data),
        .level    (level),
        .afull    (afull)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic       tr;
        logic       e_rr;
        logic       e_tv;
        logic [7:0] e_td;
        logic [2:0] e_lvl;
        logic       e_af;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT status against the queue model.
    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, "_rxd_ready"}, 32'(rxd_ready), 32'(sz != DEPTH));
        chk({tag, "_txd_valid"}, 32'(txd_valid), 32'(sz != 0));
        chk({tag, "_level"}, 32'(level), 32'(sz));
        chk({tag, "_afull"}, 32'(afull), 32'(sz >= AFULL_LVL));
        if (sz != 0) begin
            chk({tag, "_txd_data"}, 32'(txd_data), 32'(mq[0]));
        end
    endtask

    // One clock of traffic, mirrored into the queue model.
    task automatic step(input logic rv, input logic [7:0] d,
                        input logic tr, input string tag);
        logic do_push;
        logic do_pop;
        @(negedge aclk);
        rxd_valid = rv;
        rxd_data  = d;
        txd_ready = tr;
        do_push = rv && (mq.size() != DEPTH);
        do_pop  = tr && (mq.size() != 0);
        @(posedge aclk);
        if (do_pop) begin
            void'(mq.pop_front());
            n_pop++;
        end
        if (do_push) begin
            mq.push_back(d);
            n_push++;
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [7:0] held;
        int         p0;
        int         q0;
        int         cyc;

        // Fill to full, hold off a 5th beat, pop-only at full,
        // then push+pop at level 3, then drain.
        //          rv    d      tr    rr    tv    td     lvl   af
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
        tbl[5] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
        tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd2, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

        areset    = 1'b1;
        rxd_valid = 1'b1;
        rxd_data  = 8'hEE;
        txd_ready = 1'b0;

        // Reset held with rxd_valid high: nothing is stored.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rxd_ready", 32'(rxd_ready), 32'd1);
        chk("rst_txd_valid", 32'(txd_valid), 32'd0);
        chk("rst_txd_data", 32'(txd_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        rxd_valid = 1'b0;
        areset    = 1'b0;
        @(posedge aclk);
        #1;
        chk("post_rst_level", 32'(level), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            rxd_valid = tbl[i].rv;
            rxd_data  = tbl[i].d;
            txd_ready = tbl[i].tr;
            @(posedge aclk);
            #1;
            chk($sformatf("vec%0d_rxd_ready", i), 32'(rxd_ready),
                32'(tbl[i].e_rr));
            chk($sformatf("vec%0d_txd_valid", i), 32'(txd_valid),
                32'(tbl[i].e_tv));
            chk($sformatf("vec%0d_level", i), 32'(level),
                32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_afull", i), 32'(afull),
                32'(tbl[i].e_af));
            if (tbl[i].e_tv) begin
                chk($sformatf("vec%0d_txd_data", i), 32'(txd_data),
                    32'(tbl[i].e_td));
            end
        end

        // Full throughput at level 2 across several pointer wraps.
        step(1'b1, 8'h00, 1'b0, "thr_pre");
        step(1'b1, 8'h01, 1'b0, "thr_pre");
        p0 = n_push;
        q0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1, "thr");
            chk("thr_level_const", 32'(level), 32'd2);
        end
        chk("thr_beats_in", 32'(n_push - p0), 32'd20);
        chk("thr_beats_out", 32'(n_pop - q0), 32'd20);
        step(1'b0, 8'h00, 1'b1, "thr_drain");
        step(1'b0, 8'h00, 1'b1, "thr_drain");
        chk("thr_empty", 32'(txd_valid), 32'd0);

        // Backpressure: head data stays put while not accepted.
        step(1'b1, 8'hC3, 1'b0, "bp");
        step(1'b1, 8'h3C, 1'b0, "bp");
        held = txd_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'($urandom), 1'b0, "bp_hold");
            chk("bp_hold_data", 32'(txd_data), 32'(held));
            chk("bp_hold_valid", 32'(txd_valid), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, "bp_drain");
        step(1'b0, 8'h00, 1'b1, "bp_drain");

        // Random traffic against the queue model.
        p0  = n_push;
        q0  = n_pop;
        cyc = 0;
        while ((n_push - p0) < 1000 && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, "rnd");
            cyc++;
        end
        while (mq.size() != 0 && cyc < 20000) begin
            step(1'b0, 8'h00, 1'b1, "rnd_drain");
            cyc++;
        end
        chk("rnd_budget", 32'(cyc < 20000), 32'd1);
        chk("rnd_in_eq_out", 32'(n_pop - q0), 32'(n_push - p0));

        // Mid-operation reset discards contents at once.
        step(1'b1, 8'h01, 1'b0, "mr_fill");
        step(1'b1, 8'h02, 1'b0, "mr_fill");
        step(1'b1, 8'h03, 1'b0, "mr_fill");
        @(negedge aclk);
        rxd_valid = 1'b0;
        txd_ready = 1'b0;
        areset    = 1'b1;
        #1;
        chk("mr_txd_valid", 32'(txd_valid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_afull", 32'(afull), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        mq.delete();
        step(1'b1, 8'hA5, 1'b0, "mr_push");
        chk("mr_first_out", 32'(txd_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, "mr_drain");
        chk("mr_empty", 32'(txd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
